// File: rtl/decode_pkg.sv
// decode_pkg: MIPS-subset opcode/funct encodings, ALU codes and the ID/EX control bundle.
`default_nettype none

package decode_pkg;

  localparam int RA_W = 5;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_MFHI = 3'b100;
  localparam logic [2:0] ALU_MFLO = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_UPPER = 2'd2
  } immsel_t;

  typedef struct packed {
    logic            memtoreg;
    logic            memwrite;
    logic            isbranch;
    logic            brtype;
    logic            alusrcbimm;
    immsel_t         immsel;
    logic            regwrite;
    logic            dojump;
    logic            link;
    logic [2:0]      alucontrol;
    logic [RA_W-1:0] destreg;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [15:0]     imm16;
    logic [25:0]     target26;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/decode_comb.sv
// decode_comb: purely combinational instruction word -> ctrl_t plus hazard/legality flags.
`default_nettype none

module decode_comb
  import decode_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        is_load_o,
  output logic        uses_rt_o,
  output logic        is_mul_o,
  output logic        reads_hilo_o,
  output logic        is_illegal_o
);

  localparam logic [RA_W-1:0] LINK_REG = RA_W'((1 << REG_AW) - 1);

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [RA_W-1:0] rd;
  logic            regwrite_raw;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign rd    = instr_i[15:11];

  always_comb begin
    ctrl_o       = '0;
    is_load_o    = 1'b0;
    uses_rt_o    = 1'b0;
    is_mul_o     = 1'b0;
    reads_hilo_o = 1'b0;
    is_illegal_o = 1'b0;
    regwrite_raw = 1'b0;
    // Raw fields travel regardless of decode so execute can read operands directly.
    ctrl_o.rs       = instr_i[25:21];
    ctrl_o.rt       = instr_i[20:16];
    ctrl_o.imm16    = instr_i[15:0];
    ctrl_o.target26 = instr_i[25:0];
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU:  begin ctrl_o.alucontrol = ALU_ADD; regwrite_raw = 1'b1; uses_rt_o = 1'b1; ctrl_o.destreg = rd; end
          FN_SUBU:  begin ctrl_o.alucontrol = ALU_SUB; regwrite_raw = 1'b1; uses_rt_o = 1'b1; ctrl_o.destreg = rd; end
          FN_AND:   begin ctrl_o.alucontrol = ALU_AND; regwrite_raw = 1'b1; uses_rt_o = 1'b1; ctrl_o.destreg = rd; end
          FN_OR:    begin ctrl_o.alucontrol = ALU_OR;  regwrite_raw = 1'b1; uses_rt_o = 1'b1; ctrl_o.destreg = rd; end
          FN_SLTU:  begin ctrl_o.alucontrol = ALU_SLT; regwrite_raw = 1'b1; uses_rt_o = 1'b1; ctrl_o.destreg = rd; end
          FN_MULTU: begin ctrl_o.alucontrol = ALU_MUL; uses_rt_o = 1'b1; is_mul_o = 1'b1; ctrl_o.destreg = rd; end
          FN_MFHI:  begin ctrl_o.alucontrol = ALU_MFHI; regwrite_raw = 1'b1; reads_hilo_o = 1'b1; ctrl_o.destreg = rd; end
          FN_MFLO:  begin ctrl_o.alucontrol = ALU_MFLO; regwrite_raw = 1'b1; reads_hilo_o = 1'b1; ctrl_o.destreg = rd; end
          default:  is_illegal_o = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (instr_i[20:16] == 5'd0) begin
          ctrl_o.alucontrol = ALU_SLT;
          ctrl_o.isbranch   = 1'b1;
          ctrl_o.brtype     = 1'b1;
        end else begin
          is_illegal_o = 1'b1;
        end
      end
      OP_J:   ctrl_o.dojump = 1'b1;
      OP_JAL: begin
        ctrl_o.dojump  = 1'b1;
        ctrl_o.link    = 1'b1;
        regwrite_raw   = 1'b1;
        ctrl_o.destreg = LINK_REG;
      end
      OP_BEQ: begin
        ctrl_o.alucontrol = ALU_SUB;
        ctrl_o.isbranch   = 1'b1;
        uses_rt_o         = 1'b1;
      end
      OP_ADDIU: begin
        ctrl_o.alucontrol = ALU_ADD; ctrl_o.alusrcbimm = 1'b1; ctrl_o.immsel = IMM_SIGN;
        regwrite_raw = 1'b1; ctrl_o.destreg = instr_i[20:16];
      end
      OP_ORI: begin
        ctrl_o.alucontrol = ALU_OR; ctrl_o.alusrcbimm = 1'b1; ctrl_o.immsel = IMM_ZERO;
        regwrite_raw = 1'b1; ctrl_o.destreg = instr_i[20:16];
      end
      OP_LUI: begin
        ctrl_o.alucontrol = ALU_OR; ctrl_o.alusrcbimm = 1'b1; ctrl_o.immsel = IMM_UPPER;
        regwrite_raw = 1'b1; ctrl_o.destreg = instr_i[20:16];
      end
      OP_LW: begin
        ctrl_o.alucontrol = ALU_ADD; ctrl_o.alusrcbimm = 1'b1; ctrl_o.immsel = IMM_SIGN;
        ctrl_o.memtoreg = 1'b1; regwrite_raw = 1'b1; ctrl_o.destreg = instr_i[20:16];
        is_load_o = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alucontrol = ALU_ADD; ctrl_o.alusrcbimm = 1'b1; ctrl_o.immsel = IMM_SIGN;
        ctrl_o.memwrite = 1'b1; uses_rt_o = 1'b1;
      end
      default: is_illegal_o = 1'b1;
    endcase
    // $0 is hardwired, so a write to it is simply dropped here.
    ctrl_o.regwrite = regwrite_raw && (ctrl_o.destreg != '0);
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// decode_stage: registered ID/EX stage with load-use and HI/LO interlocks and flush.
// Optional DECODE_ILLEGAL_TRAP_EN: undefined encodings pulse illegal_o and block input until reset.
`default_nettype none

module decode_stage
  import decode_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int REG_AW      = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output ctrl_t       out_ctrl_o
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_o
`endif
);

  ctrl_t      dec_ctrl;
  logic       dec_is_load, dec_uses_rt, dec_is_mul, dec_reads_hilo, dec_is_illegal;
  logic       out_valid_q, out_valid_d;
  ctrl_t      out_ctrl_q, out_ctrl_d;
  logic       load_q, load_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       loaduse, mulbusy, advance, accept, take_illegal, trap_block;

  decode_comb #(.REG_AW(REG_AW)) u_decode_comb (
    .instr_i      (in_instr_i),
    .ctrl_o       (dec_ctrl),
    .is_load_o    (dec_is_load),
    .uses_rt_o    (dec_uses_rt),
    .is_mul_o     (dec_is_mul),
    .reads_hilo_o (dec_reads_hilo),
    .is_illegal_o (dec_is_illegal)
  );

  assign loaduse = out_valid_q && load_q && (out_ctrl_q.destreg != '0) &&
                   ((out_ctrl_q.destreg == dec_ctrl.rs) ||
                    (dec_uses_rt && (out_ctrl_q.destreg == dec_ctrl.rt)));
  assign mulbusy = (mul_cnt_q != 4'd0) && (dec_is_mul || dec_reads_hilo);

  assign advance    = !out_valid_q || out_ready_i || flush_i;
  assign in_ready_o = (!out_valid_q || out_ready_i) && !flush_i && !loaduse && !mulbusy && !trap_block;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    load_d      = load_q;
    // Any advance without a usable accept (flush, stall, trap) leaves a bubble.
    if (advance) begin
      out_valid_d = accept && !take_illegal;
      out_ctrl_d  = out_valid_d ? dec_ctrl : '0;
      load_d      = out_valid_d && dec_is_load;
    end
    if (accept && dec_is_mul)
      mul_cnt_d = 4'(MUL_LATENCY);
    else if (mul_cnt_q != 4'd0)
      mul_cnt_d = mul_cnt_q - 4'd1;
    else
      mul_cnt_d = 4'd0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      load_q      <= 1'b0;
      mul_cnt_q   <= 4'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      load_q      <= load_d;
      mul_cnt_q   <= mul_cnt_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d, blocked_q, blocked_d;

  assign take_illegal = dec_is_illegal;
  assign illegal_d    = accept && dec_is_illegal;
  assign blocked_d    = blocked_q || illegal_d;
  assign trap_block   = blocked_q;
  assign illegal_o    = illegal_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      illegal_q <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
      blocked_q <= blocked_d;
    end
  end
`else
  logic unused_illegal;

  assign take_illegal   = 1'b0;
  assign trap_block     = 1'b0;
  assign unused_illegal = dec_is_illegal;
`endif

  assign out_valid_o = out_valid_q;
  assign out_ctrl_o  = out_ctrl_q;

endmodule

`default_nettype wire
